// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// Shared types and helpers for the synctimer scheduler and its deadline tracker.
// All time arithmetic is modular, so a late test never compares absolute values.
package jellyvl_etherneco_synctimer_pkg;

  localparam int TIMER_WIDTH  = 64;
  localparam int PERIOD_WIDTH = 32;

  typedef logic [TIMER_WIDTH-1:0]  t_time;
  typedef logic [PERIOD_WIDTH-1:0] t_period;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } t_sched_state;

  // now has reached deadline when the wrapped difference is non-negative
  function automatic logic is_late(input t_time now, input t_time deadline);
    t_time diff;
    diff = now - deadline;
    return ~diff[TIMER_WIDTH-1];
  endfunction

  // a zero period would freeze the grid, so it behaves as one time unit
  function automatic t_time eff_period(input t_period p);
    return (p == '0) ? t_time'(1) : t_time'(p);
  endfunction

endpackage

// File: rtl/jellyvl_etherneco_synctimer_deadline.sv
// Deadline register for the sync grid: load, per-slot advance with resync when
// hopelessly behind, and one-period catch-up while a pending slot is blocked.
module jellyvl_etherneco_synctimer_deadline
  import jellyvl_etherneco_synctimer_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_reset,
  input  t_time   i_now,
  input  t_period i_period,
  input  logic    i_load,
  input  logic    i_advance,
  input  logic    i_hold,
  output logic    o_late,
  output logic    o_miss
);

  t_time r_deadline;
  t_time w_step;
  t_time w_next;
  logic  w_next_late;

  always_comb begin
    w_step      = eff_period(i_period);
    w_next      = r_deadline + w_step;
    w_next_late = is_late(i_now, w_next);
  end

  assign o_late = is_late(i_now, r_deadline);
  // every whole slot that slips past counts once, either at the advance or while held
  assign o_miss = (i_advance || i_hold) && w_next_late;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_deadline <= '0;
    end else if (i_load) begin
      r_deadline <= i_now + w_step;
    end else if (i_advance) begin
      r_deadline <= w_next_late ? (i_now + w_step) : w_next;
    end else if (i_hold && w_next_late) begin
      r_deadline <= w_next;
    end
  end

endmodule

// File: rtl/jellyvl_etherneco_synctimer_scheduler.sv
// Synctimer master sequencer: issues grid-aligned sync commands, tracks each
// response, picks override vs. correct mode and reports link sync health.
module jellyvl_etherneco_synctimer_scheduler
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int OVERRIDE_COUNT = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int RETRY_MAX      = 3
)(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  input  logic [TIMER_WIDTH-1:0]  i_current_time,
  input  logic                    i_tx_ready,
  output logic                    o_cmd_tx_start,
  output logic                    o_cmd_tx_override,
  output logic                    o_cmd_tx_correct,
  input  logic                    i_res_rx_end,
  input  logic                    i_res_rx_error,
  output logic                    o_synced,
  output logic [15:0]             o_fail_count,
  output logic [15:0]             o_miss_count,
  output logic                    o_busy
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int OVR_W = $clog2(OVERRIDE_COUNT + 1);
  localparam int STK_W = $clog2(RETRY_MAX + 1);

  t_sched_state     r_state;
  t_sched_state     w_state_next;
  logic [TMR_W-1:0] r_timer;
  logic [OVR_W-1:0] r_ovr_cnt;
  logic [STK_W-1:0] r_streak;
  logic [15:0]      r_fail_count;
  logic [15:0]      r_miss_count;
  logic             r_synced;

  logic w_load;
  logic w_advance;
  logic w_hold;
  logic w_late;
  logic w_miss;
  logic w_success;
  logic w_failure;
  logic w_override;

  jellyvl_etherneco_synctimer_deadline u_deadline (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_now     (i_current_time),
    .i_period  (i_period),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_hold    (w_hold),
    .o_late    (w_late),
    .o_miss    (w_miss)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_hold       = 1'b0;
    w_success    = 1'b0;
    w_failure    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_enable) begin
          w_load       = 1'b1;
          w_state_next = SLOT;
        end
      end
      SLOT: begin
        if (!i_enable) begin
          w_state_next = IDLE;
        end else if (w_late) begin
          if (i_tx_ready) w_state_next = START;
          else            w_hold       = 1'b1;
        end
      end
      START: begin
        w_advance    = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        // a frame arriving on the timeout cycle still decides the outcome
        if (i_res_rx_end) begin
          w_success = !i_res_rx_error;
          w_failure = i_res_rx_error;
        end else if (r_timer == '0) begin
          w_failure = 1'b1;
        end
        if (w_success || w_failure) w_state_next = i_enable ? SLOT : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_ovr_cnt    <= '0;
      r_streak     <= '0;
      r_fail_count <= '0;
      r_miss_count <= '0;
      r_synced     <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (r_state == START)                    r_timer <= TMR_W'(TIMEOUT_CYCLES - 1);
      else if (r_state == WAIT && r_timer != '0) r_timer <= r_timer - 1'b1;

      if (w_success) begin
        if (r_ovr_cnt < OVR_W'(OVERRIDE_COUNT)) r_ovr_cnt <= r_ovr_cnt + 1'b1;
        r_streak <= '0;
      end else if (w_failure) begin
        // a full failure streak forces the slaves to be overwritten again
        if (r_streak >= STK_W'(RETRY_MAX - 1)) begin
          r_ovr_cnt <= '0;
          r_streak  <= '0;
        end else begin
          r_streak <= r_streak + 1'b1;
        end
      end

      if (w_failure && r_fail_count != 16'hFFFF) r_fail_count <= r_fail_count + 16'd1;
      if (w_miss    && r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;

      // isolated failures keep the link synced; only a full streak clears ovr_cnt
      r_synced <= (r_ovr_cnt >= OVR_W'(OVERRIDE_COUNT));
    end
  end

  assign w_override        = (r_ovr_cnt < OVR_W'(OVERRIDE_COUNT));
  assign o_cmd_tx_start    = (r_state == START);
  assign o_cmd_tx_override = (r_state == START) &&  w_override;
  assign o_cmd_tx_correct  = (r_state == START) && !w_override;
  assign o_synced          = r_synced;
  assign o_fail_count      = r_fail_count;
  assign o_miss_count      = r_miss_count;
  assign o_busy            = (r_state != IDLE);

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_scheduler.sv
// Bench for the synctimer scheduler: table of exchange outcomes plus hand-written
// wrap, blocked-slot, disable, async reset and zero-period sequences.
module tb_jellyvl_etherneco_synctimer_scheduler;
  import jellyvl_etherneco_synctimer_pkg::*;

  localparam int OVC   = 4;
  localparam int TOC   = 40;
  localparam int RTM   = 3;
  localparam int STEP  = 10;
  localparam int PER   = 1000;
  localparam int SLOTC = PER / STEP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tx_ready = 1'b1;
  logic        res_end = 1'b0;
  logic        res_err = 1'b0;
  logic [31:0] period = PER;
  logic [63:0] time_base = '0;
  logic [63:0] time_off = '0;
  logic [63:0] cur_time;
  logic        start, ovr, cor, synced, busy;
  logic [15:0] fail_cnt, miss_cnt;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {logic ovr; logic cor;} exp_cmd_t;
  exp_cmd_t sb[$];

  typedef struct {int kind; logic e_ovr; logic e_synced; int e_fail;} vec_t;
  vec_t vt[14];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    time_off <= time_off + 64'(STEP);
    cyc      <= cyc + 1;
  end
  assign cur_time = time_base + time_off;

  jellyvl_etherneco_synctimer_scheduler #(
    .OVERRIDE_COUNT(OVC), .TIMEOUT_CYCLES(TOC), .RETRY_MAX(RTM)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_enable(enable), .i_period(period),
    .i_current_time(cur_time), .i_tx_ready(tx_ready),
    .o_cmd_tx_start(start), .o_cmd_tx_override(ovr), .o_cmd_tx_correct(cor),
    .i_res_rx_end(res_end), .i_res_rx_error(res_err),
    .o_synced(synced), .o_fail_count(fail_cnt), .o_miss_count(miss_cnt), .o_busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_start(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (start) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL start_wait: no cmd_tx_start within %0d cycles", maxc);
    end
  endtask

  // expected mode goes on the scoreboard before the start is awaited
  task automatic expect_start(input string name, input logic e_ovr, input int maxc, output int at);
    exp_cmd_t e;
    bit got;
    sb.push_back('{e_ovr, !e_ovr});
    wait_start(maxc, got);
    at = cyc;
    e  = sb.pop_front();
    if (got) begin
      chk({name, "_override"}, ovr, e.ovr);
      chk({name, "_correct"},  cor, e.cor);
    end
  endtask

  // kind: 0 ok, 1 error frame, 2 no response, 3 ok frame on the timeout cycle
  task automatic respond(input int kind);
    int n;
    logic [15:0] f0;
    f0 = fail_cnt;
    n  = 0;
    if (kind <= 1) begin
      @(posedge clk); #1 res_end = 1'b1; res_err = (kind == 1);
      @(posedge clk); #1 res_end = 1'b0; res_err = 1'b0;
    end else if (kind == 3) begin
      repeat (TOC) @(posedge clk);
      #1 res_end = 1'b1;
      @(posedge clk); #1 res_end = 1'b0;
    end else begin
      while (n < TOC + 10) begin
        @(posedge clk); #1 n++;
        if (fail_cnt != f0) break;
      end
      chk("timeout_len", 64'(n), 64'(TOC + 1));
    end
  endtask

  initial begin
    int at, prev, en_cyc, s, nst;
    vt[0]  = '{0, 1'b1, 1'b0, 0};
    vt[1]  = '{0, 1'b1, 1'b0, 0};
    vt[2]  = '{0, 1'b1, 1'b0, 0};
    vt[3]  = '{0, 1'b1, 1'b1, 0};
    vt[4]  = '{0, 1'b0, 1'b1, 0};
    vt[5]  = '{2, 1'b0, 1'b1, 1};
    vt[6]  = '{2, 1'b0, 1'b1, 2};
    vt[7]  = '{2, 1'b0, 1'b0, 3};
    vt[8]  = '{0, 1'b1, 1'b0, 3};
    vt[9]  = '{1, 1'b1, 1'b0, 4};
    vt[10] = '{0, 1'b1, 1'b0, 4};
    vt[11] = '{3, 1'b1, 1'b0, 4};
    vt[12] = '{0, 1'b1, 1'b1, 4};
    vt[13] = '{1, 1'b0, 1'b1, 5};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", start, 0);   chk("rst_busy", busy, 0);
    chk("rst_synced", synced, 0); chk("rst_fail", fail_cnt, 0);
    chk("rst_miss", miss_cnt, 0); chk("rst_override", ovr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 chk("idle_busy", busy, 0);

    // outcome table: override phase, timeouts, error frames, frame-vs-timeout race
    enable = 1'b1; en_cyc = cyc; prev = 0;
    for (int i = 0; i < 14; i++) begin
      expect_start($sformatf("row%0d", i), vt[i].e_ovr, 250, at);
      if (i == 0) chk("first_latency", 64'(at - en_cyc), 64'(SLOTC + 1));
      else        chk($sformatf("row%0d_spacing", i), 64'(at - prev), 64'(SLOTC));
      prev = at;
      respond(vt[i].kind);
      @(posedge clk); #1;
      chk($sformatf("row%0d_synced", i), synced, vt[i].e_synced);
      chk($sformatf("row%0d_fail", i), fail_cnt, 64'(vt[i].e_fail));
    end

    // wrap of the time base through 2^64
    #1 enable = 1'b0;
    @(posedge clk); #1 chk("disable_busy", busy, 0);
    time_base = 64'hFFFF_FFFF_FFFF_F63C - time_off;
    enable = 1'b1; en_cyc = cyc;
    for (int i = 0; i < 4; i++) begin
      expect_start($sformatf("wrap%0d", i), 1'b0, 250, at);
      if (i == 0) chk("wrap_latency", 64'(at - en_cyc), 64'(SLOTC + 1));
      else        chk($sformatf("wrap%0d_spacing", i), 64'(at - prev), 64'(SLOTC));
      prev = at;
      respond(0);
    end
    chk("wrap_time_passed_zero", 64'(cur_time < 64'd100000), 1);

    // blocked tx path for three slots
    s = prev; nst = 0;
    tx_ready = 1'b0;
    while (cyc < s + 320) begin
      @(negedge clk);
      if (start) nst++;
    end
    chk("hold_no_start", 64'(nst), 0);
    tx_ready = 1'b1;
    expect_start("release", 1'b0, 10, at);
    chk("release_time", 64'(at - s), 64'(320 + 1));
    chk("miss_count", miss_cnt, 2);
    respond(0);
    expect_start("regrid", 1'b0, 150, at);
    chk("regrid_time", 64'(at - s), 64'(4 * SLOTC));

    // enable drop while waiting finishes the exchange then idles
    @(posedge clk); #1 enable = 1'b0; res_end = 1'b1;
    @(posedge clk); #1 res_end = 1'b0;
    chk("disable_wait_busy", busy, 0);
    nst = 0;
    repeat (150) begin @(negedge clk); if (start) nst++; end
    chk("disabled_no_start", 64'(nst), 0);

    // async reset in the middle of an exchange
    @(posedge clk); #1 enable = 1'b1;
    expect_start("pre_reset", 1'b0, 250, at);
    @(posedge clk); #1 rst_n = 1'b0; period = '0;
    #1;
    chk("areset_busy", busy, 0);     chk("areset_synced", synced, 0);
    chk("areset_fail", fail_cnt, 0); chk("areset_miss", miss_cnt, 0);
    chk("areset_start", start, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // zero period keeps starting, one pulse each, none while an exchange is open
    for (int i = 0; i < 3; i++) begin
      expect_start($sformatf("p0_%0d", i), 1'b1, 20, at);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk($sformatf("p0_%0d_pulse%0d", i, k), start, 0);
        chk($sformatf("p0_%0d_busy%0d", i, k), busy, 1);
      end
      @(posedge clk); #1 res_end = 1'b1;
      @(posedge clk); #1 res_end = 1'b0;
    end
    chk("p0_fail", fail_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
